// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-field helpers for the N-way data cache.
package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      REFILL,
      DONE
   } state_t;

   // Byte-offset bits inside one cache line.
   function automatic int unsigned off_bits(input int unsigned line_w);
      return $clog2(line_w / 8);
   endfunction

   // Set-index bits.
   function automatic int unsigned idx_bits(input int unsigned sets);
      return $clog2(sets);
   endfunction

   // Tag bits: whatever is left of the byte address.
   function automatic int unsigned tag_bits(input int unsigned addr_w, input int unsigned line_w,
                                            input int unsigned sets);
      return addr_w - off_bits(line_w) - idx_bits(sets);
   endfunction

   // Word-select bits; kept at least one bit wide so ports never collapse to zero width.
   function automatic int unsigned wsel_bits(input int unsigned line_w, input int unsigned data_w);
      return (line_w > data_w) ? $clog2(line_w / data_w) : 1;
   endfunction

   // Way-number bits; at least one bit wide for the direct-mapped case.
   function automatic int unsigned way_bits(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic int unsigned addr_index(input logic [63:0] a, input int unsigned line_w,
                                              input int unsigned sets);
      return 32'((a >> off_bits(line_w)) % 64'(sets));
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] a, input int unsigned line_w,
                                            input int unsigned sets);
      return a >> (off_bits(line_w) + idx_bits(sets));
   endfunction

   function automatic int unsigned addr_word(input logic [63:0] a, input int unsigned line_w,
                                             input int unsigned data_w);
      return 32'((a >> $clog2(data_w / 8)) % 64'(line_w / data_w));
   endfunction

endpackage

// File: rtl/dcache_nway_array.sv
// dcache_nway_array: tag/valid/dirty/data storage with per-way read of one set,
// a word-merge write port for store hits and a whole-line fill port for refills.
module dcache_nway_array #(
   parameter int unsigned WAYS   = 2,
   parameter int unsigned SETS   = 16,
   parameter int unsigned LINE_W = 256,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 23,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned WSEL_W = 3,
   parameter int unsigned WAY_W  = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [IDX_W-1:0]               i_index,
   output logic [WAYS-1:0]                o_valid,
   output logic [WAYS-1:0]                o_dirty,
   output logic [WAYS-1:0][TAG_W-1:0]     o_tag,
   output logic [WAYS-1:0][LINE_W-1:0]    o_line,
   input  logic                           i_wr_en,
   input  logic [WAY_W-1:0]               i_wr_way,
   input  logic [WSEL_W-1:0]              i_wr_word,
   input  logic [DATA_W-1:0]              i_wr_data,
   input  logic                           i_fill_en,
   input  logic [WAY_W-1:0]               i_fill_way,
   input  logic [TAG_W-1:0]               i_fill_tag,
   input  logic [LINE_W-1:0]              i_fill_line
);

   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [LINE_W-1:0] r_data  [SETS][WAYS];

   // Present every way of the addressed set combinationally.
   always_comb begin
      o_valid = r_valid[i_index];
      o_dirty = r_dirty[i_index];
      for (int unsigned w = 0; w < WAYS; w++) begin
         o_tag[w]  = r_tag[i_index][w];
         o_line[w] = r_data[i_index][w];
      end
   end

   // Storage update: a refill replaces a whole way, a store hit merges one word.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
               r_tag[s][w]  <= '0;
               r_data[s][w] <= '0;
            end
         end
      end else if (i_fill_en) begin
         r_valid[i_index][i_fill_way] <= 1'b1;
         r_dirty[i_index][i_fill_way] <= 1'b0;
         r_tag[i_index][i_fill_way]   <= i_fill_tag;
         r_data[i_index][i_fill_way]  <= i_fill_line;
      end else if (i_wr_en) begin
         r_data[i_index][i_wr_way][32'(i_wr_word)*DATA_W +: DATA_W] <= i_wr_data;
         r_dirty[i_index][i_wr_way] <= 1'b1;
      end
   end

endmodule

// File: rtl/dcache_nway_ctrl.sv
// dcache_nway_ctrl: N-way set-associative, write-back, write-allocate data cache
// controller. Stalls the pipeline on a miss and runs writeback/refill with memory.
// Build option: DCACHE_PLRU_EN selects tree pseudo-LRU replacement; when undefined
// each set uses a round-robin fill pointer.
module dcache_nway_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LINE_W = 256,
   parameter int unsigned SETS   = 16,
   parameter int unsigned WAYS   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_MemRead_i,
   input  logic              cpu_MemWrite_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic [DATA_W-1:0] cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   localparam int unsigned OFF_W  = off_bits(LINE_W);
   localparam int unsigned IDX_W  = idx_bits(SETS);
   localparam int unsigned TAG_W  = tag_bits(ADDR_W, LINE_W, SETS);
   localparam int unsigned WSEL_W = wsel_bits(LINE_W, DATA_W);
   localparam int unsigned WAY_W  = way_bits(WAYS);

   state_t                     r_state, w_next;
   logic [WAY_W-1:0]           r_victim;

   logic                       w_req, w_hit, w_any_inv, w_hit_upd;
   logic [WAY_W-1:0]           w_hit_way, w_inv_way, w_policy, w_vsel;
   logic [IDX_W-1:0]           w_idx;
   logic [TAG_W-1:0]           w_tag;
   logic [WSEL_W-1:0]          w_word;
   logic [WAYS-1:0]            w_valid, w_dirty;
   logic [WAYS-1:0][TAG_W-1:0] w_tags;
   logic [WAYS-1:0][LINE_W-1:0] w_lines;
   logic                       w_arr_wr, w_fill;

   assign w_req  = cpu_MemRead_i | cpu_MemWrite_i;
   assign w_idx  = IDX_W'(addr_index(64'(cpu_addr_i), LINE_W, SETS));
   assign w_tag  = TAG_W'(addr_tag(64'(cpu_addr_i), LINE_W, SETS));
   assign w_word = WSEL_W'(addr_word(64'(cpu_addr_i), LINE_W, DATA_W));
   assign w_hit_upd = (r_state == IDLE) && w_req && w_hit;

   dcache_nway_array #(
      .WAYS   (WAYS),
      .SETS   (SETS),
      .LINE_W (LINE_W),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .IDX_W  (IDX_W),
      .WSEL_W (WSEL_W),
      .WAY_W  (WAY_W)
   ) u_array (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_index     (w_idx),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_tags),
      .o_line      (w_lines),
      .i_wr_en     (w_arr_wr),
      .i_wr_way    (w_hit_way),
      .i_wr_word   (w_word),
      .i_wr_data   (cpu_data_i),
      .i_fill_en   (w_fill),
      .i_fill_way  (r_victim),
      .i_fill_tag  (w_tag),
      .i_fill_line (mem_data_i)
   );

   // Hit detection and first-invalid search over the addressed set (lowest way wins).
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_any_inv = 1'b0;
      w_inv_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!w_hit && w_valid[w] && (w_tags[w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!w_any_inv && !w_valid[w]) begin
            w_any_inv = 1'b1;
            w_inv_way = WAY_W'(w);
         end
      end
   end

`ifdef DCACHE_PLRU_EN
   localparam int unsigned PL_W = (WAYS > 1) ? WAYS - 1 : 1;
   localparam int unsigned LVL  = $clog2(WAYS);

   logic [PL_W-1:0] r_plru [SETS];

   // Tree nodes are heap-numbered from 1; a node bit of 0 points the victim walk left.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] t);
      int unsigned node;
      logic        b;
      node = 1;
      for (int unsigned l = 0; l < LVL; l++) begin
         b = 1'b0;
         for (int unsigned n = 0; n < PL_W; n++)
            if (n == node - 1) b = t[n];
         node = 2 * node + (b ? 1 : 0);
      end
      return WAY_W'(node - WAYS);
   endfunction

   // Point every node on the path to the touched way away from it.
   function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t,
                                                 input logic [WAY_W-1:0] way);
      logic [PL_W-1:0] r;
      int unsigned     node, bitv;
      r    = t;
      node = 1;
      for (int unsigned l = 0; l < LVL; l++) begin
         bitv = (32'(way) >> (LVL - 1 - l)) & 32'd1;
         for (int unsigned n = 0; n < PL_W; n++)
            if (n == node - 1) r[n] = (bitv == 0);
         node = 2 * node + bitv;
      end
      return r;
   endfunction

   assign w_policy = plru_victim(r_plru[w_idx]);

   // Pseudo-LRU state follows every hit and every fill.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned s = 0; s < SETS; s++) r_plru[s] <= '0;
      end else if (w_fill) begin
         r_plru[w_idx] <= plru_touch(r_plru[w_idx], r_victim);
      end else if (w_hit_upd) begin
         r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
      end
   end
`else
   logic [WAY_W-1:0] r_rr [SETS];

   assign w_policy = r_rr[w_idx];

   // Round-robin pointer advances on each fill into its set.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned s = 0; s < SETS; s++) r_rr[s] <= '0;
      end else if (w_fill) begin
         r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
      end
   end
`endif

   // Victim: first invalid way, else the replacement policy's choice.
   always_comb begin
      w_vsel = w_any_inv ? w_inv_way : w_policy;
      if (WAYS == 1) w_vsel = '0;
   end

   // State register and victim capture at miss detection.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= IDLE;
         r_victim <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == IDLE) && w_req && !w_hit) r_victim <= w_vsel;
      end
   end

   // Next-state and memory-side outputs; memory outputs are pure functions of state.
   always_comb begin
      w_next       = r_state;
      w_arr_wr     = 1'b0;
      w_fill       = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (w_hit) w_arr_wr = cpu_MemWrite_i;
               else       w_next   = MISS;
            end
         end
         MISS: begin
            w_next = (w_valid[r_victim] && w_dirty[r_victim]) ? WRITEBACK : REFILL;
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {w_tags[r_victim], w_idx, {OFF_W{1'b0}}};
            mem_data_o   = w_lines[r_victim];
            if (mem_ack_i) w_next = REFILL;
         end
         REFILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
            if (mem_ack_i) begin
               w_fill = 1'b1;
               w_next = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Load data is combinational from the hitting way; zero when nothing hits.
   always_comb begin
      cpu_data_o = '0;
      if (w_hit) cpu_data_o = w_lines[w_hit_way][32'(w_word)*DATA_W +: DATA_W];
   end

   // Stall unless the request completes as an IDLE hit this cycle.
   always_comb begin
      cpu_stall_o = w_req && !((r_state == IDLE) && w_hit);
   end

endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// tb_dcache_nway_ctrl: randomized and directed self-checking bench for dcache_nway_ctrl.
// The reference model keeps per-set line contents, LRU ages and a round-robin count,
// plus a backing memory, and predicts data, stall length and the memory request order.
module tb_dcache_nway_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 256;
   localparam int unsigned NS = 16;
   localparam int unsigned NW = 2;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cpu_MemRead_i, cpu_MemWrite_i;
   logic [AW-1:0] cpu_addr_i;
   logic [DW-1:0] cpu_data_i, cpu_data_o;
   logic          cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_data_o, mem_data_i;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   dcache_nway_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .LINE_W (LW),
      .SETS   (NS),
      .WAYS   (NW)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .cpu_MemRead_i  (cpu_MemRead_i),
      .cpu_MemWrite_i (cpu_MemWrite_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_data_i     (cpu_data_i),
      .cpu_data_o     (cpu_data_o),
      .cpu_stall_o    (cpu_stall_o),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_data_i     (mem_data_i),
      .mem_ack_i      (mem_ack_i)
   );

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Backing memory, line-addressed; untouched lines get a deterministic pattern.
   logic [LW-1:0] mem [int unsigned];

   function automatic logic [LW-1:0] mem_line(input int unsigned la);
      logic [LW-1:0] l;
      if (mem.exists(la)) return mem[la];
      for (int unsigned w = 0; w < LW / DW; w++)
         l[w*DW +: DW] = (la * 3 + w * 32'h1111) ^ 32'h5A5A0000;
      return l;
   endfunction

   // Reference cache contents.
   bit              m_valid [NS][NW];
   bit              m_dirty [NS][NW];
   int unsigned     m_tag   [NS][NW];
   logic [LW-1:0]   m_data  [NS][NW];
   longint unsigned m_age   [NS][NW];
   int unsigned     m_rr    [NS];
   longint unsigned m_time;

   typedef struct {
      bit            wr;
      int unsigned   addr;
      logic [LW-1:0] data;
   } mreq_t;
   mreq_t expq[$];

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
            m_age[s][w]   = 0;
         end
      end
      m_time = 0;
      expq.delete();
   endtask

   // One CPU access from posedge+1 until the completing cycle's edge; fw<0 picks random ack waits.
   task automatic access(input bit rd, input bit wr, input int unsigned addr,
                         input logic [DW-1:0] wdata, input int fw,
                         output int st, output logic [DW-1:0] rdv, output int nreq);
      int unsigned s, tg, wd, la, v;
      int          hw, exp_bus, wcnt;
      bit          miss, busy, fin;
      logic [DW-1:0] exp_rd;
      mreq_t       cur;
      s  = (addr >> 5) % NS;
      tg = addr >> 9;
      wd = (addr >> 2) % (LW / DW);
      la = addr & ~32'h1F;
      hw = -1;
      for (int w = 0; w < NW; w++)
         if (hw < 0 && m_valid[s][w] && m_tag[s][w] == tg) hw = w;
      miss = (hw < 0);
      if (miss) begin
         v = NW;
         for (int w = 0; w < NW; w++)
            if (v == NW && !m_valid[s][w]) v = w;
         if (v == NW) begin
`ifdef DCACHE_PLRU_EN
            v = 0;
            for (int w = 1; w < NW; w++)
               if (m_age[s][w] < m_age[s][v]) v = w;
`else
            v = m_rr[s];
`endif
         end
         if (m_valid[s][v] && m_dirty[s][v])
            expq.push_back('{1'b1, (m_tag[s][v] << 9) | (s << 5), m_data[s][v]});
         expq.push_back('{1'b0, la, '0});
         m_valid[s][v] = 1;
         m_dirty[s][v] = 0;
         m_tag[s][v]   = tg;
         m_data[s][v]  = mem_line(la);
         m_rr[s]       = (m_rr[s] + 1) % NW;
         m_age[s][v]   = ++m_time;
         hw = v;
      end
      m_age[s][hw] = ++m_time;
      exp_rd = m_data[s][hw][wd*DW +: DW];
      if (wr) begin
         m_data[s][hw][wd*DW +: DW] = wdata;
         m_dirty[s][hw] = 1;
      end

      cpu_MemRead_i  = rd;
      cpu_MemWrite_i = wr;
      cpu_addr_i     = addr;
      cpu_data_i     = wdata;
      st = 0; nreq = 0; exp_bus = 0; busy = 0; fin = 0; wcnt = 0;
      while (!fin) begin
         @(negedge clk);
         if (!cpu_stall_o) begin
            fin = 1;
         end else begin
            st++;
            if (mem_enable_o) begin
               if (!busy) begin
                  busy = 1;
                  nreq++;
                  wcnt = (fw >= 0) ? fw : int'($urandom_range(0, 3));
                  exp_bus += wcnt + 1;
                  if (expq.size() == 0) begin
                     check("extra_req", mem_addr_o, '1);
                     cur = '{mem_write_o, mem_addr_o, mem_data_o};
                  end else begin
                     cur = expq.pop_front();
                     check("req_kind", mem_write_o, cur.wr);
                     check("req_addr", mem_addr_o, cur.addr);
                     if (cur.wr) check("wb_data", mem_data_o, cur.data);
                  end
               end
               if (wcnt == 0) begin
                  mem_ack_i = 1;
                  if (cur.wr) mem[cur.addr] = mem_data_o;
                  else        mem_data_i = mem_line(cur.addr);
                  busy = 0;
               end else begin
                  wcnt--;
               end
            end
            if (st >= 80) begin
               check("timeout", st, miss ? 3 + exp_bus : 0);
               fin = 1;
            end
            @(posedge clk);
            #1;
            mem_ack_i = 0;
         end
      end
      rdv = cpu_data_o;
      if (st < 80) begin
         check("stall", st, miss ? 3 + exp_bus : 0);
         check("no_mem_on_hit", mem_enable_o, 1'b0);
         if (rd && !wr) check("rdata", cpu_data_o, exp_rd);
         check("reqs_left", expq.size(), 0);
         @(posedge clk);
         #1;
      end
      expq.delete();
      cpu_MemRead_i  = 0;
      cpu_MemWrite_i = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int            st, nreq;
      logic [DW-1:0] rd;
      logic [LW-1:0] l;
      bit            seen;
      int unsigned   a;
      bit            r, w;

      rst_i = 0; cpu_MemRead_i = 0; cpu_MemWrite_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
      mem_ack_i = 0; mem_data_i = '0;
      model_reset();
      @(negedge clk);
      check("rst_stall", cpu_stall_o, 1'b0);
      check("rst_cpu_data", cpu_data_o, '0);
      check("rst_mem_en", mem_enable_o, 1'b0);
      check("rst_mem_wr", mem_write_o, 1'b0);
      check("rst_mem_addr", mem_addr_o, '0);
      check("rst_mem_data", mem_data_o, '0);
      rst_i = 1;
      @(posedge clk);
      #1;

      // Cold read of 0x100, memory answers after three wait cycles.
      l = mem_line(32'h100);
      l[31:0] = 32'hDEADBEEF;
      mem[32'h100] = l;
      access(1, 0, 32'h100, '0, 3, st, rd, nreq);
      check("cold_rd_value", rd, 32'hDEADBEEF);
      check("cold_rd_reqs", nreq, 1);
      access(1, 0, 32'h100, '0, -1, st, rd, nreq);
      check("repeat_rd_stall", st, 0);

      // Store hit, then load it back.
      access(0, 1, 32'h104, 32'h55AA, -1, st, rd, nreq);
      check("wr_hit_stall", st, 0);
      access(1, 0, 32'h104, '0, -1, st, rd, nreq);
      check("rd_after_wr", rd, 32'h0000_55AA);

      // Conflict in set 8: 0x100 dirty, 0x2100 clean, then 0x4100.
      access(1, 0, 32'h2100, '0, -1, st, rd, nreq);
      access(1, 0, 32'h100, '0, -1, st, rd, nreq);
      access(1, 0, 32'h4100, '0, -1, st, rd, nreq);
`ifdef DCACHE_PLRU_EN
      check("evict_reqs", nreq, 1);
`else
      check("evict_reqs", nreq, 2);
`endif
      access(1, 0, 32'h104, '0, -1, st, rd, nreq);
      access(1, 0, 32'h2100, '0, -1, st, rd, nreq);

      // Reset while a refill is outstanding.
      cpu_MemRead_i = 1;
      cpu_addr_i    = 32'h1E0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_enable_o && !mem_write_o) seen = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("rf_seen", seen, 1'b1);
      check("rf_addr", mem_addr_o, 32'h1E0);
      rst_i = 0;
      cpu_MemRead_i = 0;
      #1;
      check("mid_rst_stall", cpu_stall_o, 1'b0);
      check("mid_rst_en", mem_enable_o, 1'b0);
      check("mid_rst_addr", mem_addr_o, '0);
      check("mid_rst_cpu_data", cpu_data_o, '0);
      @(posedge clk);
      #1;
      rst_i = 1;
      model_reset();

      // Post-reset miss with ack in the same cycle enable rises.
      access(1, 0, 32'h100, '0, 0, st, rd, nreq);
      check("stall4", st, 4);

      // Random traffic over four tags x four sets to force frequent dirty evictions.
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
         r = $urandom_range(0, 1);
         w = $urandom_range(0, 1);
         if (!r && !w) r = 1;
         access(r, w, a, $urandom, -1, st, rd, nreq);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dcache_nway_ctrl.md
# dcache_nway_ctrl

Parametrised N-way set-associative, write-back, write-allocate data cache. It sits between the EX/MEM pipeline register and the line-wide data memory. It holds tag, valid, dirty and data arrays internally. It stalls the pipeline on a miss and runs the writeback and refill handshake with memory.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, CPU word width
- LINE_W, 256, cache line width in bits (power of two, multiple of DATA_W)
- SETS, 16, number of sets (power of two, ≥2)
- WAYS, 2, associativity (power of two, 1..8)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_addr_i  in  ADDR_W  byte address, word aligned
- cpu_data_i  in  DATA_W  store data
- cpu_data_o  out  DATA_W  load data
- cpu_stall_o  out  1  freeze pipeline
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = writeback, 0 = refill
- mem_addr_o  out  ADDR_W  line-aligned address
- mem_data_o  out  LINE_W  writeback line
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  request complete; refill data valid same cycle

## Operation
- Address split:
  - offset = log2(LINE_W/8) LSBs; word select = offset[MSB:log2(DATA_W/8)]
  - index = next log2(SETS) bits
  - tag = remainder
- Request = read | write. If both are asserted, it is a write.
- Hit = any way in the set is valid with a matching tag.
- States:
  - IDLE:
    - Request hit: no stall. A read returns the selected word. A write merges the word into the line and sets dirty.
    - Request miss: choose victim, go to MISS.
  - MISS:
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to REFILL.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, addr={victim tag, index, 0}, data = victim line. On ack, go to REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, addr={req tag, index, 0}. On ack, write mem_data_i into the victim way, set valid=1, dirty=0, tag = request tag, and go to DONE.
  - DONE: go to IDLE. The access then hits and completes there; a write sets dirty.
- Victim selection: the first invalid way (lowest index). If all ways are valid, the replacement policy picks the victim (see Configuration).
- cpu_stall_o = request & ~(state==IDLE & hit).

## Timing
- Reset values:
  - state=IDLE
  - all valid/dirty=0; replacement state=0
  - cpu_stall_o=0, cpu_data_o=0
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0
- Hit: 0-cycle latency; cpu_data_o is combinational from the arrays. Store data commits at the edge ending the cycle.
- Clean miss: stall for IDLE, MISS, REFILL (≥1 cycle), DONE, then the hit cycle; 3 + refill-wait cycles of stall.
- Dirty miss: adds WRITEBACK (≥1 cycle).
- mem_enable_o is a level signal, held with stable address and data until mem_ack_i is sampled high. It drops the cycle after ack. mem_ack_i is ignored while mem_enable_o=0.
- Request inputs must stay stable while cpu_stall_o=1.
- Reset asserted mid-transaction aborts the transaction immediately and invalidates all lines. Dirty data is lost; the memory is expected to be reset too.
- Ack in the same cycle as enable rises is legal: one-cycle WRITEBACK or REFILL.

## Configuration
- DCACHE_PLRU_EN:
  - Defined: tree pseudo-LRU per set, WAYS-1 bits. It updates on every hit and every fill toward the accessed way; the victim is the PLRU leaf.
  - Undefined: one round-robin pointer per set, log2(WAYS) bits, incremented on each fill into that set.
  - WAYS=1 ignores the macro.

## Structure
- Package dcache_pkg:
  - state enum (IDLE, MISS, WRITEBACK, REFILL, DONE)
  - localparam functions for offset/index/tag widths
  - address field extraction helpers
- Sub-module dcache_nway_array: tag/valid/dirty/data storage with per-way read of the indexed set, word-merge write and line fill. The controller FSM, hit logic and replacement logic stay in the top module.

## Test plan
- Reset, read 0x100 with memory returning line L (word0=0xDEADBEEF) and ack after 3 cycles → one REFILL request at addr 0x100; cpu_data_o=0xDEADBEEF once stall drops; a repeat read has no stall.
- Write 0x55AA to 0x104 (hit), then read 0x104 → returns 0x000055AA with zero stall; dirty=1 and no memory traffic.
- WAYS=2: fill sets via 0x100, 0x2100, then 0x4100, where 0x100 is dirty → WRITEBACK of the 0x100 line (its data intact), then REFILL of 0x4100, in that order.
- Macro on: access 0x100, 0x2100, 0x100, then 0x4100 → 0x2100 is evicted. Macro off → 0x100 is evicted.
- Assert rst_i low during REFILL wait → all outputs zero next evaluation; a read of 0x100 then misses.
- Ack in the same cycle enable rises → single-cycle REFILL; total stall 4 cycles.
